matmul_engine: RTL and testbench

Parametrised matrix-multiply engine, successor to matrix_multiplier. It computes C = A·B (A is M×K, B is K×N, all row-major, signed fixed-point) from on-chip SRAM over an Avalon-MM master port.
- LANES output columns are computed in parallel, so each A element is fetched once per column block.
- Sizes and base addresses come from ports rather than memory.
- The master port supports waitrequest and variable read latency.
- A start/busy/done handshake lets the ICA/ECG control CPU sequence multiplications.

---
 rtl/matmul_pkg.sv | 33 +++
 rtl/matmul_engine_mac_lane.sv | 46 ++++
 rtl/matmul_engine.sv | 201 ++++++++++++++++++++
 tb/tb_matmul_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply engine.
// Accumulator width derivation and the signed range check used to saturate C.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RD_A,
    RD_B,
    WR,
    DONE
  } state_t;

  localparam int MAX_W = 128;

  function automatic int acc_width(input int dw, input int gw);
    return 2 * dw + gw;
  endfunction

  function automatic logic sat_ovf(
    input logic signed [MAX_W-1:0] v,
    input int dw
  );
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    one = 1;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -hi - one;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/matmul_engine_mac_lane.sv
// One output-column accumulator: signed MAC with Q-format
// shift and saturation on the way out.
module mac_lane
  import matmul_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] q,
  output logic              ovf
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sh;
  logic signed [MAX_W-1:0]    wide;

  assign prod = $signed(a) * $signed(b);
  assign sh   = acc >>> FRAC_BITS;
  assign wide = MAX_W'(sh);
  assign ovf  = sat_ovf(wide, DATA_W);

  always_comb begin
    q = sh[DATA_W-1:0];
    if (ovf) begin
      q = sh[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                      : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// C = A*B over an Avalon-MM master, LANES output
// columns per block, one read outstanding at a time.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ADDR_W    = 14,
  parameter int DIM_W     = 10,
  parameter int LANES     = 4,
  parameter int GUARD_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  size_m,
  input  logic [DIM_W-1:0]  size_k,
  input  logic [DIM_W-1:0]  size_n,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              sat,
  output logic [ADDR_W-1:0] address,
  output logic              chip_select,
  output logic [3:0]        byte_enable,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              waitrequest,
  input  logic              readdatavalid
);

  localparam int ACC_W = acc_width(DATA_W, GUARD_W);
  localparam int PW    = ADDR_W + DIM_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  state_t state, nxt;

  logic [DIM_W-1:0]  m_r, k_r, n_r;
  logic [DIM_W-1:0]  i, j0, k, l;
  logic [ADDR_W-1:0] ba, bb, bc;
  logic [DATA_W-1:0] a_q;
  logic              pend;

  logic [DIM_W-1:0] rem, nl;
  logic [DIM_W:0]   j_nxt;
  logic             last_l, rd_ok, zero;
  logic             k_last, j_last, i_last;
  logic [LW-1:0]    lane_idx;
  logic [PW-1:0]    off_a, off_b, off_c;

  logic [LANES-1:0]  en, ovf;
  logic [DATA_W-1:0] lane_q [LANES];

  assign rem      = n_r - j0;
  assign nl       = (rem < DIM_W'(LANES)) ? rem : DIM_W'(LANES);
  assign last_l   = (l == nl - 1'b1);
  assign lane_idx = l[LW-1:0];
  assign rd_ok    = pend && readdatavalid;
  assign zero     = (size_m == '0) || (size_k == '0) || (size_n == '0);
  assign j_nxt    = {1'b0, j0} + (DIM_W+1)'(LANES);
  assign k_last   = ({1'b0, k} + (DIM_W+1)'(1)) >= {1'b0, k_r};
  assign j_last   = j_nxt >= {1'b0, n_r};
  assign i_last   = ({1'b0, i} + (DIM_W+1)'(1)) >= {1'b0, m_r};

  assign off_a = PW'(i) * PW'(k_r) + PW'(k);
  assign off_b = PW'(k) * PW'(n_r) + PW'(j0) + PW'(l);
  assign off_c = PW'(i) * PW'(n_r) + PW'(j0) + PW'(l);

  assign chip_select = read | write;
  assign byte_enable = {4{chip_select}};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign en[g] = (state == RD_B) && rd_ok
                && (lane_idx == LW'(g));
    mac_lane #(
      .DATA_W   (DATA_W),
      .FRAC_BITS(FRAC_BITS),
      .ACC_W    (ACC_W)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .clear(state == CLEAR),
      .en   (en[g]),
      .a    (a_q),
      .b    (read_data),
      .q    (lane_q[g]),
      .ovf  (ovf[g])
    );
  end

  always_comb begin
    nxt        = state;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    write_data = '0;
    unique case (state)
      IDLE: if (start) nxt = zero ? DONE : CLEAR;
      CLEAR: nxt = RD_A;
      RD_A: begin
        read    = !pend;
        address = ADDR_W'(PW'(ba) + off_a);
        if (rd_ok) nxt = RD_B;
      end
      RD_B: begin
        read    = !pend;
        address = ADDR_W'(PW'(bb) + off_b);
        if (rd_ok && last_l) nxt = k_last ? WR : RD_A;
      end
      WR: begin
        write      = 1'b1;
        address    = ADDR_W'(PW'(bc) + off_c);
        write_data = lane_q[lane_idx];
        if (!waitrequest && last_l)
          nxt = (j_last && i_last) ? DONE : CLEAR;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      sat   <= 1'b0;
      pend  <= 1'b0;
      m_r   <= '0;
      k_r   <= '0;
      n_r   <= '0;
      ba    <= '0;
      bb    <= '0;
      bc    <= '0;
      i     <= '0;
      j0    <= '0;
      k     <= '0;
      l     <= '0;
      a_q   <= '0;
    end else begin
      state <= nxt;
      done  <= (state == DONE);
      unique case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          error <= zero;
          sat   <= 1'b0;
          m_r   <= size_m;
          k_r   <= size_k;
          n_r   <= size_n;
          ba    <= base_a;
          bb    <= base_b;
          bc    <= base_c;
          i     <= '0;
          j0    <= '0;
        end
        CLEAR: begin
          k <= '0;
          l <= '0;
        end
        RD_A, RD_B: begin
          if (read && !waitrequest) pend <= 1'b1;
          if (rd_ok) begin
            pend <= 1'b0;
            if (state == RD_A) begin
              a_q <= read_data;
            end else if (last_l) begin
              l <= '0;
              k <= k + 1'b1;
            end else begin
              l <= l + 1'b1;
            end
          end
        end
        WR: if (!waitrequest) begin
          sat <= sat | ovf[lane_idx];
          if (last_l) begin
            l <= '0;
            if (j_last) begin
              j0 <= '0;
              i  <= i + 1'b1;
            end else begin
              j0 <= j_nxt[DIM_W-1:0];
            end
          end else begin
            l <= l + 1'b1;
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: memory slave
// with stalls/latency, table vectors and random jobs.
module tb_matmul_engine;

  localparam int AW  = 14;
  localparam int MSK = (1 << AW) - 1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [9:0]  size_m, size_k, size_n;
  logic [13:0] base_a, base_b, base_c;
  logic        busy, done, error, sat;
  logic [13:0] address;
  logic        chip_select, read, write;
  logic [3:0]  byte_enable;
  logic [31:0] write_data, read_data;
  logic        waitrequest, readdatavalid;

  matmul_engine dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .size_m       (size_m),
    .size_k       (size_k),
    .size_n       (size_n),
    .base_a       (base_a),
    .base_b       (base_b),
    .base_c       (base_c),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .sat          (sat),
    .address      (address),
    .chip_select  (chip_select),
    .byte_enable  (byte_enable),
    .read         (read),
    .write        (write),
    .write_data   (write_data),
    .read_data    (read_data),
    .waitrequest  (waitrequest),
    .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Avalon slave model
  logic [31:0] mem [0:MSK];
  int          lat = 1;
  bit          rw = 0;
  int          rd_cnt = 0;
  logic [13:0] rd_addr;
  int          nrd = 0, nwr = 0, dones = 0;
  int          stab_viol = 0, outst_viol = 0;
  bit          stab_en = 1;
  bit          p_stall = 0, p_rd = 0, p_wr = 0;
  logic [13:0] p_addr;
  logic [31:0] p_wd;
  logic [13:0] wa_q [$];
  logic [31:0] wd_q [$];

  initial begin
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    read_data     = '0;
  end

  always @(negedge clk) begin
    readdatavalid = 1'b0;
    read_data     = $urandom;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        readdatavalid = 1'b1;
        read_data     = mem[rd_addr];
      end
    end
    waitrequest = rw ? 1'($urandom_range(0, 1)) : 1'b0;
    if (stab_en && p_stall) begin
      if (read !== p_rd || write !== p_wr || address !== p_addr ||
          (p_wr && write_data !== p_wd))
        stab_viol++;
    end
    if (read && !waitrequest) begin
      if (rd_cnt != 0) outst_viol++;
      rd_cnt  = lat;
      rd_addr = address;
      nrd++;
    end
    if (write && !waitrequest) begin
      mem[address] = write_data;
      wa_q.push_back(address);
      wd_q.push_back(write_data);
      nwr++;
    end
    if (done) dones++;
    p_stall = (read || write) && waitrequest;
    p_rd    = read;
    p_wr    = write;
    p_addr  = address;
    p_wd    = write_data;
  end

  // Reference model operating on whole matrices
  logic [31:0] ga [25];
  logic [31:0] gb [25];
  logic [31:0] ec [25];
  bit          esat;
  int          erd;

  task automatic ref_model(input int m, input int k, input int n);
    logic signed [127:0] s;
    longint p;
    esat = 0;
    erd  = 0;
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int t = 0; t < k; t++) begin
          p = longint'($signed(ga[r*k+t])) * longint'($signed(gb[t*n+c]));
          s = s + 128'(p);
        end
        s = s >>> 16;
        if (s > 128'sh7FFFFFFF) begin
          ec[r*n+c] = 32'h7FFFFFFF;
          esat = 1;
        end else if (s < -128'sh80000000) begin
          ec[r*n+c] = 32'h80000000;
          esat = 1;
        end else begin
          ec[r*n+c] = s[31:0];
        end
      end
      for (int j = 0; j < n; j += 4)
        erd += k * (1 + ((n - j < 4) ? n - j : 4));
    end
  endtask

  task automatic load(input int m, input int k, input int n,
                      input int ba, input int bb, input int bc);
    for (int x = 0; x < m * k; x++) mem[(ba + x) & MSK] = ga[x];
    for (int x = 0; x < k * n; x++) mem[(bb + x) & MSK] = gb[x];
    for (int x = 0; x < m * n; x++) mem[(bc + x) & MSK] = 32'hDEADBEEF;
    size_m = 10'(m);
    size_k = 10'(k);
    size_n = 10'(n);
    base_a = 14'(ba);
    base_b = 14'(bb);
    base_c = 14'(bc);
  endtask

  int  cyc, ndone;
  bit  busy1, busy_at_done;

  task automatic run_job();
    int d0;
    d0 = dones;
    nrd = 0;
    nwr = 0;
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    while (done !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) chk("timeout", 0, 1);
    busy_at_done = busy;
    repeat (3) @(negedge clk);
    ndone = dones - d0;
  endtask

  task automatic run_case(input string tag, input int m, input int k,
                          input int n, input int ba, input int bb,
                          input int bc);
    int bad;
    load(m, k, n, ba, bb, bc);
    ref_model(m, k, n);
    run_job();
    chk({tag, "_done_cnt"}, 64'(ndone), 1);
    chk({tag, "_busy"}, {busy1, busy_at_done}, 2'b10);
    chk({tag, "_error"}, 64'(error), 0);
    chk({tag, "_sat"}, 64'(sat), 64'(esat));
    chk({tag, "_reads"}, 64'(nrd), 64'(erd));
    chk({tag, "_writes"}, 64'(nwr), 64'(m * n));
    bad = 0;
    for (int x = 0; x < m * n && x < wa_q.size(); x++) begin
      if (wa_q[x] !== 14'((bc + x) & MSK)) bad++;
      if (wd_q[x] !== ec[x]) bad++;
    end
    chk({tag, "_c_words"}, 64'(bad), 0);
  endtask

  typedef struct {
    int m, k, n, lat;
    bit rw, esat;
    logic [3:0][31:0] a;
    logic [4:0][31:0] b;
    logic [4:0][31:0] c;
  } vec_t;

  vec_t tv [5];

  function automatic vec_t mk(input int m, input int k, input int n,
                              input int l, input bit w, input bit s);
    vec_t v;
    v.m = m; v.k = k; v.n = n; v.lat = l; v.rw = w; v.esat = s;
    v.a = '0; v.b = '0; v.c = '0;
    return v;
  endfunction

  initial begin
    int d0, t;
    bit found;
    reset  = 1'b1;
    start  = 1'b0;
    size_m = '0; size_k = '0; size_n = '0;
    base_a = '0; base_b = '0; base_c = '0;

    tv[0] = mk(2, 2, 2, 1, 0, 0);
    tv[0].a[0] = 32'h10000; tv[0].a[3] = 32'h10000;
    for (int x = 0; x < 4; x++) begin
      tv[0].b[x] = 32'((x + 1) << 16);
      tv[0].c[x] = 32'((x + 1) << 16);
    end
    tv[1] = mk(1, 1, 5, 1, 0, 0);
    tv[1].a[0] = 32'h20000;
    for (int x = 0; x < 5; x++) begin
      tv[1].b[x] = 32'((x + 1) << 16);
      tv[1].c[x] = 32'((2 * x + 2) << 16);
    end
    tv[2] = mk(1, 1, 1, 1, 0, 1);
    tv[2].a[0] = 32'h7FFF0000; tv[2].b[0] = 32'h7FFF0000;
    tv[2].c[0] = 32'h7FFFFFFF;
    tv[3] = mk(1, 1, 1, 1, 0, 1);
    tv[3].a[0] = 32'h80000000; tv[3].b[0] = 32'h7FFF0000;
    tv[3].c[0] = 32'h80000000;
    tv[4] = tv[0];
    tv[4].lat = 3;
    tv[4].rw  = 1;

    repeat (3) @(negedge clk);
    chk("rst_flags", {busy, done, error, sat}, 4'b0);
    chk("rst_bus", {read, write, chip_select, byte_enable}, 7'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      lat = tv[v].lat;
      rw  = tv[v].rw;
      for (int x = 0; x < 4; x++) ga[x] = tv[v].a[x];
      for (int x = 0; x < 5; x++) gb[x] = tv[v].b[x];
      run_case($sformatf("vec%0d", v), tv[v].m, tv[v].k, tv[v].n,
               'h10, 'h40, 'h80);
      chk($sformatf("vec%0d_sat_tbl", v), 64'(sat), 64'(tv[v].esat));
      for (int x = 0; x < tv[v].m * tv[v].n; x++)
        chk($sformatf("vec%0d_c%0d", v, x), mem['h80 + x], tv[v].c[x]);
    end

    // zero-size job
    lat = 1;
    rw  = 0;
    load(2, 0, 2, 'h10, 'h40, 'h80);
    run_job();
    chk("zero_latency", 64'(cyc), 2);
    chk("zero_bus", {32'(nrd), 32'(nwr)}, 64'b0);
    chk("zero_flags", {error, sat}, 2'b10);
    chk("zero_busy", {busy1, busy_at_done}, 2'b10);
    chk("zero_done_cnt", 64'(ndone), 1);
    for (int x = 0; x < 4; x++) ga[x] = tv[0].a[x];
    for (int x = 0; x < 4; x++) gb[x] = tv[0].b[x];
    run_case("after_zero", 2, 2, 2, 'h10, 'h40, 'h80);

    // reset while reading B
    load(2, 2, 2, 'h10, 'h40, 'h80);
    d0 = dones;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    t = 0;
    while (!found && t < 200) begin
      @(negedge clk);
      t++;
      if (read && address >= 14'h40 && address < 14'h44) found = 1;
    end
    chk("rdb_seen", 64'(found), 1);
    stab_en = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out", {read, write, busy, done}, 4'b0);
    repeat (10) @(negedge clk);
    chk("midrst_nodone", 64'(dones - d0), 0);
    stab_en = 1;
    run_case("after_rst", 2, 2, 2, 'h10, 'h40, 'h80);

    // random jobs
    for (int r = 0; r < 20; r++) begin
      int m, k, n, ba;
      m = $urandom_range(1, 5);
      k = $urandom_range(1, 5);
      n = $urandom_range(1, 5);
      ba  = (r == 0) ? MSK - 10 : int'($urandom_range(0, MSK));
      lat = $urandom_range(1, 3);
      rw  = 1'($urandom_range(0, 1));
      for (int x = 0; x < 25; x++) begin
        if (r % 2 == 0) begin
          ga[x] = $urandom;
          gb[x] = $urandom;
        end else begin
          ga[x] = 32'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
          gb[x] = 32'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
        end
      end
      run_case($sformatf("rnd%0d", r), m, k, n, ba,
               (ba + 64) & MSK, (ba + 128) & MSK);
    end

    chk("bus_stable", 64'(stab_viol), 0);
    chk("one_outstanding", 64'(outst_viol), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
